// File: rtl/alu_iterative_exec.sv
// Execute-stage ALU: logic/arith/compare in one cycle, shifts iterate one bit per cycle.
// Latency: 1 cycle for non-shift ops and zero-length shifts, n+1 cycles for a shift by n.
// Backpressure: in_ready only in IDLE; result/branch_taken held in DONE until out_ready.
module alu_iterative_exec #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            operation,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  branch_taken
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_BNE = 4'b1001;
    localparam logic [3:0] OP_BLT = 4'b1010;
    localparam logic [3:0] OP_BGE = 4'b1011;
    localparam logic [3:0] OP_SLL = 4'b1100;
    localparam logic [3:0] OP_SRL = 4'b1101;
    localparam logic [3:0] OP_SRA = 4'b1110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  work_q, work_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;
    logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]             op_q, op_d;
    logic                   branch_q, branch_d;

    logic [DATA_WIDTH-1:0]  alu_res;
    logic [DATA_WIDTH-1:0]  shifted;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   alu_br;
    logic                   cond;
    logic                   is_shift;

    assign shamt    = src_b[SHAMT_WIDTH-1:0];
    assign is_shift = (operation == OP_SLL) || (operation == OP_SRL) || (operation == OP_SRA);

    assign result       = result_q;
    assign branch_taken = branch_q;

    // Single-cycle datapath; compare ops (10xx) return the condition as a 0/1 result.
    always_comb begin
        alu_res = '0;
        alu_br  = 1'b0;
        cond    = 1'b0;
        case (operation)
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_BEQ:  cond = (src_a == src_b);
            OP_BNE:  cond = (src_a != src_b);
            OP_BLT:  cond = ($signed(src_a) < $signed(src_b));
            OP_BGE:  cond = ($signed(src_a) >= $signed(src_b));
            default: alu_res = '0;
        endcase
        if (operation[3:2] == 2'b10) begin
            alu_res = {{(DATA_WIDTH-1){1'b0}}, cond};
            alu_br  = cond;
        end
    end

    always_comb begin
        case (op_q)
            OP_SLL:  shifted = {work_q[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, work_q[DATA_WIDTH-1:1]};
            OP_SRA:  shifted = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
            default: shifted = work_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        result_d  = result_q;
        branch_d  = branch_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                // A flush cycle must not look like an accept to the producer.
                in_ready = !flush;
                if (in_valid && !flush) begin
                    if (is_shift) begin
                        work_d = src_a;
                        cnt_d  = shamt;
                        op_d   = operation;
                        if (shamt == '0) begin
                            result_d = src_a;
                            branch_d = 1'b0;
                            state_d  = DONE;
                        end else begin
                            state_d = SHIFT;
                        end
                    end else begin
                        result_d = alu_res;
                        branch_d = alu_br;
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - SHAMT_WIDTH'(1);
                if (cnt_q == SHAMT_WIDTH'(1)) begin
                    result_d = shifted;
                    branch_d = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything; the visible result keeps its old value.
        if (flush) begin
            state_d  = IDLE;
            work_d   = work_q;
            cnt_d    = cnt_q;
            op_d     = op_q;
            result_d = result_q;
            branch_d = branch_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            branch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            branch_q <= branch_d;
        end
    end

endmodule

// File: tb/tb_alu_iterative_exec.sv
// Bench for alu_iterative_exec: scoreboard queue filled at accept, drained on output handshake.
module tb_alu_iterative_exec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  operation = 4'h0;
    logic [31:0] src_a = 32'h0;
    logic [31:0] src_b = 32'h0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;
    logic        branch_taken;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    always #5 clk = ~clk;

    alu_iterative_exec #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .operation(operation), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .branch_taken(branch_taken)
    );

    // Scoreboard: every completed output handshake pops one expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got result=%h branch=%b, required no output", result, branch_taken);
            end else begin
                mon_e = exp_q.pop_front();
                if ({result, branch_taken} !== mon_e) begin
                    errors++;
                    $display("FAIL scoreboard: got result=%h branch=%b, required result=%h branch=%b",
                             result, branch_taken, mon_e[32:1], mon_e[0]);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        c;
        r = 32'h0;
        c = 1'b0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = a ^ b;
            4'h4: r = a + b;
            4'h5: r = a - b;
            4'h8: c = (a == b);
            4'h9: c = (a != b);
            4'hA: c = ($signed(a) < $signed(b));
            4'hB: c = !($signed(a) < $signed(b));
            4'hC: r = a << b[4:0];
            4'hD: r = a >> b[4:0];
            4'hE: r = $unsigned($signed(a) >>> b[4:0]);
            default: r = 32'h0;
        endcase
        if (op[3:2] == 2'b10) r = {31'h0, c};
        return {r, c};
    endfunction

    // Drives one op, queues its expected result, returns cycles from accept to out_valid (-1 on timeout).
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eb, output int lat);
        int w;
        @(posedge clk); #1;
        operation = op; src_a = a; src_b = b; in_valid = 1'b1;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            lat = -1;
            return;
        end
        exp_q.push_back({er, eb});
        @(posedge clk); #1;
        in_valid = 1'b0;
        operation = 4'($urandom); src_a = $urandom; src_b = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++;
        if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h, required 0", result); end
        checks++;
        if (branch_taken !== 1'b0) begin errors++; $display("FAIL reset_branch: got %b, required 0", branch_taken); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        int lat;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [32:0] e;
        send(4'h4, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d, required 1", lat); end
        send(4'h5, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b0, lat);
        send(4'h1, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, lat);
        send(4'h2, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, lat);
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 4))
                0: op = 4'h0;
                1: op = 4'h1;
                2: op = 4'h2;
                3: op = 4'h4;
                default: op = 4'h5;
            endcase
            a = $urandom; b = $urandom;
            e = model(op, a, b);
            send(op, a, b, e[32:1], e[0], lat);
            checks++;
            if (lat !== 1) begin errors++; $display("FAIL arith_latency: op=%h got %0d, required 1", op, lat); end
        end
    endtask

    task automatic test_compare();
        int lat;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [32:0] e;
        send(4'hA, 32'hFFFFFFFE, 32'h00000003, 32'h1, 1'b1, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL blt_latency: got %0d, required 1", lat); end
        send(4'hB, 32'hFFFFFFFE, 32'h00000003, 32'h0, 1'b0, lat);
        send(4'h8, 32'h5, 32'h5, 32'h1, 1'b1, lat);
        send(4'h9, 32'h5, 32'h5, 32'h0, 1'b0, lat);
        send(4'h8, 32'h5, 32'h6, 32'h0, 1'b0, lat);
        send(4'hB, 32'h80000000, 32'h80000000, 32'h1, 1'b1, lat);
        for (int i = 0; i < 6; i++) begin
            op = 4'h8 + 4'($urandom_range(0, 3));
            a = $urandom; b = (i == 0) ? a : $urandom;
            e = model(op, a, b);
            send(op, a, b, e[32:1], e[0], lat);
        end
    endtask

    task automatic test_shift();
        int lat;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [32:0] e;
        send(4'hE, 32'h80000010, 32'h00000004, 32'hF8000001, 1'b0, lat);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL sra_latency: got %0d, required 5", lat); end
        send(4'hD, 32'h80000010, 32'h00000004, 32'h08000001, 1'b0, lat);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL srl_latency: got %0d, required 5", lat); end
        send(4'hC, 32'h12345678, 32'hFFFFFFE0, 32'h12345678, 1'b0, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL sll0_latency: got %0d, required 1", lat); end
        for (int i = 0; i < 6; i++) begin
            op = 4'hC + 4'($urandom_range(0, 2));
            a = $urandom; b = $urandom;
            if (i == 0) b[4:0] = 5'd31;
            e = model(op, a, b);
            send(op, a, b, e[32:1], e[0], lat);
            checks++;
            if (lat !== ((b[4:0] == 5'd0) ? 1 : int'(b[4:0]) + 1)) begin
                errors++;
                $display("FAIL shift_latency: op=%h shamt=%0d got %0d", op, b[4:0], lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        logic [31:0] a, b;
        out_ready = 1'b1;
        acc = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            a = $urandom; b = $urandom;
            operation = 4'h4; src_a = a; src_b = b;
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({a + b, 1'b0});
                acc++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (acc !== 10) begin errors++; $display("FAIL b2b_throughput: got %0d accepts in 20 cycles, required 10", acc); end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        send(4'hC, 32'h1, 32'd31, 32'h80000000, 1'b0, lat);
        checks++;
        if (lat !== 32) begin errors++; $display("FAIL bp_latency: got %0d, required 32", lat); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; operation = 4'h4; src_a = $urandom; src_b = $urandom;
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, branch_taken, result} !== {1'b1, 1'b0, 1'b0, 32'h80000000}) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d got ov=%b ir=%b br=%b res=%h, required ov=1 ir=0 br=0 res=80000000",
                         i, out_valid, in_ready, branch_taken, result);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release: got ir=%b ov=%b, required ir=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic test_flush();
        int lat;
        logic        seen;
        logic [31:0] prev;
        prev = result;
        @(posedge clk); #1;
        in_valid = 1'b1; operation = 4'hD; src_a = 32'hDEADBEEF; src_b = 32'd20;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_pre_accept: in_ready got %b, required 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL flush_shift: got ir=%b ov=%b, required ir=1 ov=0", in_ready, out_valid);
        end
        checks++;
        if (result !== prev) begin errors++; $display("FAIL flush_result_kept: got %h, required %h", result, prev); end
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_output: out_valid got %b, required 0", seen); end
        send(4'h0, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL and_latency: got %0d, required 1", lat); end

        // Flush together with in_valid in IDLE must accept nothing.
        @(posedge clk); #1;
        in_valid = 1'b1; flush = 1'b1; operation = 4'h4; src_a = 32'h1; src_b = 32'h1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_vs_accept: out_valid got %b, required 0", out_valid); end

        // Flush in DONE drops out_valid even with out_ready high; result is kept.
        out_ready = 1'b0;
        send(4'h4, 32'h1, 32'h2, 32'h3, 1'b0, lat);
        @(posedge clk); #1;
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, result} !== {1'b0, 32'h3}) begin
            errors++;
            $display("FAIL flush_done: got ov=%b res=%h, required ov=0 res=00000003", out_valid, result);
        end
        void'(exp_q.pop_back());
    endtask

    task automatic test_async_reset();
        int lat;
        send(4'h8, 32'h7, 32'h7, 32'h1, 1'b1, lat);
        @(posedge clk); #1;
        in_valid = 1'b1; operation = 4'hE; src_a = 32'h80000000; src_b = 32'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, branch_taken, result} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL async_reset: got ir=%b ov=%b br=%b res=%h, required ir=1 ov=0 br=0 res=0",
                     in_ready, out_valid, branch_taken, result);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_partial: out_valid got %b, required 0", out_valid); end
        send(4'h7, 32'hAAAA5555, 32'h12345678, 32'h0, 1'b0, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL undef_latency: got %0d, required 1", lat); end
        send(4'h4, 32'h5, 32'h6, 32'hB, 1'b0, lat);
        send(4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, lat);
        send(4'h3, 32'h5, 32'h5, 32'h0, 1'b0, lat);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_compare();
        test_shift();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
